// File: rtl/gravador_sequencia_pkg.sv
// Shared definitions for the sequence recorder: state codes seen on db_estado
// and the memory geometry used by the recorder and its RAM.
package gravador_sequencia_pkg;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 4;

    // The game's debug display decodes db_estado with these exact codes.
    localparam logic [3:0] EST_INICIAL    = 4'd0;
    localparam logic [3:0] EST_PREPARACAO = 4'd1;
    localparam logic [3:0] EST_ESPERA     = 4'd2;
    localparam logic [3:0] EST_REGISTRA   = 4'd3;
    localparam logic [3:0] EST_GRAVA      = 4'd4;
    localparam logic [3:0] EST_CHECA      = 4'd5;
    localparam logic [3:0] EST_FIM        = 4'd15;

    typedef enum logic [3:0] {
        INICIAL    = EST_INICIAL,
        PREPARACAO = EST_PREPARACAO,
        ESPERA     = EST_ESPERA,
        REGISTRA   = EST_REGISTRA,
        GRAVA      = EST_GRAVA,
        CHECA      = EST_CHECA,
        FIM        = EST_FIM
    } estado_t;

endpackage

// File: rtl/sync_ram_16x4.sv
// 16x4 RAM with synchronous write and synchronous (read-before-write) read;
// the writable counterpart of sync_rom_16x4.
module sync_ram_16x4
    import gravador_sequencia_pkg::*;
(
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // NOTE: no reset on the array so it maps onto block RAM; contents survive reset.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[address] <= data_in;
        end
        data_out <= mem[address];
    end

endmodule

// File: rtl/gravador_sequencia.sv
// Sequence recorder: waits for each new key press, registers the switches and
// stores them at consecutive RAM addresses until position ULTIMO is written.
module gravador_sequencia
    import gravador_sequencia_pkg::*;
#(
    parameter int unsigned ULTIMO = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic [DATA_W-1:0] chaves,
    output logic              pronto,
    output logic [ADDR_W-1:0] db_contagem,
    output logic [DATA_W-1:0] db_chaves,
    output logic [DATA_W-1:0] db_memoria,
    output logic [3:0]        db_estado
);

    localparam logic [ADDR_W-1:0] ULTIMO_ADDR = ADDR_W'(ULTIMO);

    estado_t           estado_q;
    logic              pronto_q;
    logic              prev_q;
    logic [ADDR_W-1:0] contagem_q;
    logic [DATA_W-1:0] chaves_q;
    logic              jogada;
    logic              we;

    // A press is the rising edge of "any key down", so a held key counts once.
    assign jogada = (|chaves) & ~prev_q;

    // Reset wins over a write that would otherwise land on the same edge.
    assign we = (estado_q == GRAVA) && !reset;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q   <= INICIAL;
            pronto_q   <= 1'b0;
            prev_q     <= 1'b0;
            contagem_q <= '0;
            chaves_q   <= '0;
        end else begin
            prev_q <= |chaves;
            case (estado_q)
                INICIAL: begin
                    if (iniciar) estado_q <= PREPARACAO;
                end
                PREPARACAO: begin
                    contagem_q <= '0;
                    chaves_q   <= '0;
                    estado_q   <= ESPERA;
                end
                ESPERA: begin
                    if (jogada) estado_q <= REGISTRA;
                end
                REGISTRA: begin
                    chaves_q <= chaves;
                    estado_q <= GRAVA;
                end
                GRAVA: begin
                    estado_q <= CHECA;
                end
                CHECA: begin
                    // The counter stops at the last address instead of wrapping.
                    if (contagem_q == ULTIMO_ADDR) begin
                        estado_q <= FIM;
                        pronto_q <= 1'b1;
                    end else begin
                        contagem_q <= contagem_q + 1'b1;
                        estado_q   <= ESPERA;
                    end
                end
                FIM: begin
                    if (iniciar) begin
                        estado_q <= PREPARACAO;
                        pronto_q <= 1'b0;
                    end
                end
                default: begin
                    estado_q <= INICIAL;
                    pronto_q <= 1'b0;
                end
            endcase
        end
    end

    sync_ram_16x4 u_ram (
        .clock    (clock),
        .we       (we),
        .address  (contagem_q),
        .data_in  (chaves_q),
        .data_out (db_memoria)
    );

    assign pronto      = pronto_q;
    assign db_contagem = contagem_q;
    assign db_chaves   = chaves_q;
    assign db_estado   = estado_q;

endmodule

// File: tb/tb_gravador_sequencia.sv
// Directed bench for gravador_sequencia: a full-length recorder and a
// four-entry recorder (ULTIMO=3) share clock, switches and iniciar.
module tb_gravador_sequencia;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       rst3  = 1'b1;
    logic       iniciar = 1'b0;
    logic [3:0] chaves  = 4'd0;

    logic       pronto,  pronto3;
    logic [3:0] contagem, contagem3;
    logic [3:0] dchaves,  dchaves3;
    logic [3:0] memoria,  memoria3;
    logic [3:0] estado,   estado3;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    gravador_sequencia #(.ULTIMO(15)) dut (
        .clock       (clock),
        .reset       (reset),
        .iniciar     (iniciar),
        .chaves      (chaves),
        .pronto      (pronto),
        .db_contagem (contagem),
        .db_chaves   (dchaves),
        .db_memoria  (memoria),
        .db_estado   (estado)
    );

    gravador_sequencia #(.ULTIMO(3)) dut3 (
        .clock       (clock),
        .reset       (rst3),
        .iniciar     (iniciar),
        .chaves      (chaves),
        .pronto      (pronto3),
        .db_contagem (contagem3),
        .db_chaves   (dchaves3),
        .db_memoria  (memoria3),
        .db_estado   (estado3)
    );

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Press a key from espera: detect, register, write, checa -> four edges.
    task automatic press(input logic [3:0] v);
        chaves = v;
        repeat (4) tick();
    endtask

    task automatic release_keys();
        chaves = 4'd0;
        tick();
    endtask

    logic [3:0] pattern [4];

    initial begin
        pattern[0] = 4'b0001;
        pattern[1] = 4'b0010;
        pattern[2] = 4'b0100;
        pattern[3] = 4'b1000;

        // Reset then idle
        tick();
        tick();
        reset = 1'b0;
        check("rst_estado",   estado,   4'd0);
        check("rst_pronto",   {3'd0, pronto}, 4'd0);
        check("rst_contagem", contagem, 4'd0);
        check("rst_chaves",   dchaves,  4'd0);
        chaves = 4'b0100; tick();
        chaves = 4'b0000; tick();
        chaves = 4'b0001; tick();
        chaves = 4'b0000; tick();
        check("idle_estado", estado, 4'd0);

        // Full record of 16 entries
        iniciar = 1'b1; tick();
        check("start_prep", estado, 4'd1);
        iniciar = 1'b0; tick();
        check("start_espera", estado, 4'd2);
        check("start_cnt", contagem, 4'd0);
        for (int i = 0; i < 16; i++) begin
            press(pattern[i % 4]);
            check($sformatf("full_mem%0d", i), memoria, pattern[i % 4]);
            check($sformatf("full_cnt%0d", i), contagem, (i == 15) ? 4'd15 : 4'(i + 1));
            if (i == 14) check("full_pronto_low", {3'd0, pronto}, 4'd0);
            release_keys();
        end
        check("full_fim", estado, 4'd15);
        check("full_pronto", {3'd0, pronto}, 4'd1);
        chaves = 4'b0010; tick();
        chaves = 4'b0000; tick();
        check("fim_hold_cnt", contagem, 4'd15);
        check("fim_hold_estado", estado, 4'd15);

        // Held key: one write only
        iniciar = 1'b1; tick();
        check("held_prep", estado, 4'd1);
        check("held_pronto_fall", {3'd0, pronto}, 4'd0);
        iniciar = 1'b0; tick();
        check("held_cnt0", contagem, 4'd0);
        chaves = 4'b0010;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 3) check("held_mem0", memoria, 4'b0010);
        end
        check("held_cnt", contagem, 4'd1);
        check("held_estado", estado, 4'd2);
        release_keys();
        press(4'b0100);
        check("held_mem1", memoria, 4'b0100);
        check("held_cnt2", contagem, 4'd2);
        release_keys();

        // Non-one-hot value, then a press arriving outside espera
        chaves = 4'b0011; tick();
        check("out_registra", estado, 4'd3);
        tick();
        check("out_grava", estado, 4'd4);
        check("out_reg", dchaves, 4'b0011);
        chaves = 4'b0000; tick();
        check("out_checa", estado, 4'd5);
        chaves = 4'b1000; tick();
        check("out_mem2", memoria, 4'b0011);
        check("out_cnt3", contagem, 4'd3);
        repeat (3) tick();
        check("out_ignored_estado", estado, 4'd2);
        check("out_ignored_cnt", contagem, 4'd3);
        release_keys();

        // Reset while in grava at address 3 (mem[3] holds 8 from the full record)
        chaves = 4'b0110; tick();
        tick();
        check("rg_grava", estado, 4'd4);
        reset = 1'b1; tick();
        check("rg_estado", estado, 4'd0);
        check("rg_cnt", contagem, 4'd0);
        check("rg_chaves", dchaves, 4'd0);
        check("rg_pronto", {3'd0, pronto}, 4'd0);
        reset = 1'b0;
        chaves = 4'b0000;
        tick();
        check("rg_mem0", memoria, 4'b0010);
        iniciar = 1'b1; tick();
        iniciar = 1'b0; tick();
        for (int i = 0; i < 3; i++) begin
            press(4'b0001);
            release_keys();
        end
        check("rg_cnt3", contagem, 4'd3);
        check("rg_mem3_kept", memoria, 4'b1000);

        // Short recorder: record, reach fim, re-record from fim
        reset = 1'b1; rst3 = 1'b1; tick();
        reset = 1'b0; rst3 = 1'b0;
        iniciar = 1'b1; tick();
        iniciar = 1'b0; tick();
        check("u3_espera", estado3, 4'd2);
        for (int i = 0; i < 4; i++) begin
            press(pattern[3 - i]);
            check($sformatf("u3_mem%0d", i), memoria3, pattern[3 - i]);
            check($sformatf("u3_cnt%0d", i), contagem3, (i == 3) ? 4'd3 : 4'(i + 1));
            release_keys();
        end
        check("u3_fim", estado3, 4'd15);
        check("u3_pronto", {3'd0, pronto3}, 4'd1);
        check("u16_not_done", {3'd0, pronto}, 4'd0);
        check("u16_cnt4", contagem, 4'd4);
        iniciar = 1'b1; tick();
        check("u3_reprep", estado3, 4'd1);
        check("u16_iniciar_ignored", estado, 4'd2);
        iniciar = 1'b0; tick();
        check("u3_reespera", estado3, 4'd2);
        check("u3_recnt0", contagem3, 4'd0);
        press(4'b0001);
        check("u3_rewrite_mem0", memoria3, 4'b0001);
        check("u3_recnt1", contagem3, 4'd1);
        check("u16_cnt5", contagem, 4'd5);
        release_keys();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
